// File: rtl/seq_calculator_if.sv
// Request/response bundle for seq_calculator: operand handshake in, answer handshake out.
// div_err exists only when SEQ_CALC_DIVERR_EN is defined.
interface seq_calculator_if #(
    parameter int N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [1:0]     op;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] Result;
    logic           C_out;
`ifdef SEQ_CALC_DIVERR_EN
    logic           div_err;
`endif

    modport master (
        output in_valid, A, B, op, out_ready,
`ifdef SEQ_CALC_DIVERR_EN
        input  div_err,
`endif
        input  in_ready, out_valid, Result, C_out
    );

    modport slave (
        input  in_valid, A, B, op, out_ready,
`ifdef SEQ_CALC_DIVERR_EN
        output div_err,
`endif
        output in_ready, out_valid, Result, C_out
    );
endinterface

// File: rtl/seq_calculator.sv
// Sequential add/sub/mul/div unit with IDLE/BUSY/DONE handshake FSM.
// Define SEQ_CALC_DIVERR_EN to add the divide-by-zero flag (div_err).
module seq_calculator #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_calculator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    state_t         state;
    state_t         next_state;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [1:0]     op_reg;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] work;
    logic [2*N-1:0] work_next;
    logic [2*N-1:0] result;
    logic           c_out;
    logic [N:0]     sum_add;
    logic [N:0]     sum_sub;
    logic [N:0]     mul_sum;
    logic [N:0]     div_shift;
    logic [N:0]     div_trial;
    logic           accept;
    logic           last_cycle;
    logic           div_zero;
    logic           in_ready;
    logic           out_valid;

    assign div_zero = (b_reg == '0);
    assign accept   = (state == IDLE) && bus.in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) next_state = BUSY;
            end
            BUSY: begin
                if (last_cycle) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        last_cycle = 1'b0;
        unique case (op_reg)
            OP_ADD, OP_SUB: last_cycle = 1'b1;
            OP_MUL:         last_cycle = (cnt == '0);
            OP_DIV:         last_cycle = div_zero || (cnt == '0);
            default:        last_cycle = 1'b1;
        endcase
    end

    // work holds the running product (mul) or {remainder, quotient} (div).
    always_comb begin
        sum_add   = {1'b0, a_reg} + {1'b0, b_reg};
        sum_sub   = {1'b0, a_reg} + {1'b0, ~b_reg} + {{N{1'b0}}, 1'b1};
        mul_sum   = {1'b0, work[2*N-1:N]} + {1'b0, a_reg};
        div_shift = {work[2*N-1:N], work[N-1]};
        div_trial = div_shift - {1'b0, b_reg};
        work_next = work;
        if (op_reg == OP_MUL) begin
            if (work[0]) work_next = {mul_sum, work[N-1:1]};
            else         work_next = {1'b0, work[2*N-1:1]};
        end else if (op_reg == OP_DIV) begin
            if (!div_trial[N]) work_next = {div_trial[N-1:0], work[N-2:0], 1'b1};
            else               work_next = {div_shift[N-1:0], work[N-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= OP_ADD;
            cnt     <= '0;
            work    <= '0;
            result  <= '0;
            c_out   <= 1'b0;
`ifdef SEQ_CALC_DIVERR_EN
            bus.div_err <= 1'b0;
`endif
        end else if (accept) begin
            a_reg  <= bus.A;
            b_reg  <= bus.B;
            op_reg <= bus.op;
            cnt    <= CW'(N - 1);
            work   <= (bus.op == OP_MUL) ? {{N{1'b0}}, bus.B} : {{N{1'b0}}, bus.A};
        end else if (state == BUSY) begin
            work <= work_next;
            cnt  <= cnt - CW'(1);
            if (last_cycle) begin
                c_out <= 1'b0;
`ifdef SEQ_CALC_DIVERR_EN
                bus.div_err <= (op_reg == OP_DIV) && div_zero;
`endif
                unique case (op_reg)
                    OP_ADD: begin
                        result <= {{N{1'b0}}, sum_add[N-1:0]};
                        c_out  <= sum_add[N];
                    end
                    OP_SUB: begin
                        result <= {{N{1'b0}}, sum_sub[N-1:0]};
                        c_out  <= sum_sub[N];
                    end
                    OP_MUL: result <= work_next;
                    OP_DIV: result <= div_zero ? {a_reg, {N{1'b1}}} : work_next;
                    default: result <= work_next;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.Result    = result;
    assign bus.C_out     = c_out;
endmodule

// File: tb/tb_seq_calculator.sv
// Randomized scoreboard bench for seq_calculator: arithmetic reference model, latency,
// backpressure stability and mid-operation reset.
module tb_seq_calculator;
    localparam int N = 8;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef struct {
        logic [2*N-1:0] result;
        logic           c;
        logic           derr;
        int             cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    bit   hold = 1'b0;
    bit   in_done = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    seq_calculator_if #(.N(N)) bus();
    seq_calculator #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    // Reference answer computed straight from the arithmetic definitions.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] o);
        exp_t e;
        longint unsigned au = a;
        longint unsigned bu = b;
        longint unsigned mask = (64'd1 << N) - 1;
        longint unsigned r;
        e.c = 1'b0;
        e.derr = 1'b0;
        e.cyc = 1;
        case (o)
            OP_ADD: begin
                r = au + bu;
                e.c = ((r >> N) & 1) != 0;
                r = r & mask;
            end
            OP_SUB: begin
                r = (au + (mask + 1) - bu) & mask;
                e.c = (au >= bu);
            end
            OP_MUL: begin
                r = au * bu;
                e.cyc = N;
            end
            default: begin
                if (bu == 0) begin
                    r = (au << N) | mask;
                    e.derr = 1'b1;
                end else begin
                    r = ((au % bu) << N) | (au / bu);
                    e.cyc = N;
                end
            end
        endcase
        e.result = r[2*N-1:0];
        return e;
    endfunction

    // Caller sits at a negedge; accepts on the next rising edge once in_ready is seen.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] o);
        exp_t e;
        int   waited = 0;
        while (!bus.in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) begin
            reportFail("in_ready_timeout");
            return;
        end
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.op = o;
        @(negedge clk);
        e = model(a, b, o);
        e.cyc = cycle + e.cyc;
        sb.push_back(e);
        bus.in_valid = 1'b0;
        bus.A = N'($urandom);
        bus.B = N'($urandom);
        bus.op = 2'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while ((sb.size() != 0 || in_done) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) reportFail("drain_timeout");
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the expected answer when out_valid rises, then checks it holds until consumed.
    initial begin
        exp_t           e;
        logic [2*N-1:0] held_r;
        logic           held_c;
        held_r = '0;
        held_c = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_done = 1'b0;
            end else if (bus.out_valid) begin
                checkOutput("in_ready_in_done", bus.in_ready, 0);
                if (!in_done) begin
                    if (sb.size() == 0) begin
                        reportFail("unexpected_out_valid");
                    end else begin
                        e = sb.pop_front();
                        checkOutput("result", bus.Result, e.result);
                        checkOutput("c_out", bus.C_out, e.c);
                        checkOutput("latency_cycle", cycle, e.cyc);
`ifdef SEQ_CALC_DIVERR_EN
                        checkOutput("div_err", bus.div_err, e.derr);
`endif
                    end
                    held_r = bus.Result;
                    held_c = bus.C_out;
                    in_done = 1'b1;
                end else begin
                    checkOutput("result_stable", bus.Result, held_r);
                    checkOutput("c_out_stable", bus.C_out, held_c);
                end
                if (bus.out_ready) in_done = 1'b0;
            end else if (in_done) begin
                reportFail("out_valid_dropped");
                in_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog_expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        logic [N-1:0] a;
        logic [N-1:0] b;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.op = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", bus.in_ready, 1);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_result", bus.Result, 0);
        checkOutput("reset_c_out", bus.C_out, 0);
`ifdef SEQ_CALC_DIVERR_EN
        checkOutput("reset_div_err", bus.div_err, 0);
`endif
        rst = 1'b0;
        checkOutput("ready_after_reset", bus.in_ready, 1);

        $display("[TB] directed add/sub");
        applyStimulus(8'd200, 8'd100, OP_ADD);
        applyStimulus(8'd5, 8'd7, OP_SUB);
        applyStimulus(8'd7, 8'd5, OP_SUB);
        drain();

        $display("[TB] mul with backpressure");
        hold = 1'b1;
        applyStimulus(8'd255, 8'd255, OP_MUL);
        w = 0;
        while (!bus.out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) reportFail("mul_valid_timeout");
        repeat (5) @(negedge clk);
        hold = 1'b0;
        drain();

        $display("[TB] div and divide by zero");
        applyStimulus(8'd100, 8'd7, OP_DIV);
        applyStimulus(8'd9, 8'd0, OP_DIV);
        drain();

        $display("[TB] reset during mul");
        applyStimulus(8'd13, 8'd11, OP_MUL);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", bus.out_valid, 0);
        checkOutput("abort_result", bus.Result, 0);
        checkOutput("abort_c_out", bus.C_out, 0);
        checkOutput("abort_in_ready", bus.in_ready, 1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'd150, 8'd150, OP_ADD);
        drain();

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            a = N'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            applyStimulus(a, b, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
